ex_unit_sched: RTL and testbench
================================

Name: ex_unit_sched

Overview:
- Controller that shares the RV32IF execute datapath (integer ALU plus FPU, selected by a 2-bit extension code) between two issue requesters.
- Arbitrates between the requesters round-robin and drives operands and control into the datapath, holding them stable.
- Counts the per-class latency, samples result and flags, and returns them on a tagged valid/ready response channel.
- Sits between decode/issue and writeback; one operation in flight at a time.

Parameters:
- WIDTH, 32, operand/result width.
- INT_LATENCY, 1, datapath settle cycles for integer ops (min 1).
- FP_LATENCY, 4, datapath settle cycles for FP ops (min 1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  abort in-flight op and drop pending response.
- req0_valid / req1_valid  input  1  requester has an op.
- req0_ready / req1_ready  output  1  op accepted this cycle.
- req0_opa, req0_opb / req1_opa, req1_opb  input  WIDTH  operands.
- req0_ctrl / req1_ctrl  input  4  ALU/FPU operation code.
- req0_ext / req1_ext  input  2  extension; 2'b11 = FP op, else integer op.
- dp_opa, dp_opb  output  WIDTH  datapath operands.
- dp_ctrl  output  4  datapath op code.
- dp_ext  output  2  datapath extension select.
- dp_result  input  WIDTH  datapath result.
- dp_zero, dp_sign  input  1  integer flags.
- dp_exception, dp_overflow, dp_underflow  input  1  FP flags.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer takes response.
- rsp_id  output  1  requester index of response.
- rsp_result  output  WIDTH  captured result.
- rsp_flags  output  5  {zero, sign, exception, overflow, underflow}.
- busy  output  1  state != IDLE.

Behaviour:
- Reset values: state IDLE, all dp_* 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_flags 0, rr pointer 0, req*_ready 0, busy 0.
- FSM states: IDLE, EXEC, DONE.
- IDLE grant rules:
  - req_ready is combinational, high only in IDLE and only for the granted requester.
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not served last (rr pointer); pointer updates on every accept.
  - None valid: stay in IDLE.
- Accept (valid & ready at edge N): capture opa/opb/ctrl/ext into dp_* regs and capture id; load cnt = (ext==2'b11 ? FP_LATENCY : INT_LATENCY) - 1; go to EXEC.
- EXEC:
  - dp_* held constant.
  - cnt decrements each cycle.
  - When cnt==0, sample dp_result and flags into rsp_* regs and go to DONE.
  - EXEC lasts exactly L cycles, so rsp_valid first rises at cycle N+1+L.
- Flag masking:
  - Integer op: exception/overflow/underflow bits forced 0.
  - FP op: zero/sign bits forced 0.
- DONE:
  - rsp_valid=1; rsp_* stable while rsp_valid & !rsp_ready.
  - rsp_valid & rsp_ready: go to IDLE (one-cycle bubble; no accept in the same cycle).
- flush:
  - In any state, at the next edge: go to IDLE, rsp_valid=0, no response for the aborted op.
  - flush in IDLE: no effect; req_ready forced 0 that cycle.
  - rr pointer unchanged by flush.
- dp_* hold the last issued values in IDLE; no toggling without an accept.
- Async rst mid-EXEC or mid-DONE: immediate return to reset values; the op is lost.
- Latency values below 1 are illegal and not required to be handled.

Test Plan:
- Integer op: req0 ext=00, opa=5, opb=5, SUB op code, datapath returns 0 with zero=1. Accept at cycle N → rsp_valid at N+2, rsp_id=0, rsp_result=0, rsp_flags=5'b10000.
- FP op: req1 ext=11, FP_LATENCY=4, datapath returns 0x7F800000 with overflow=1. Accept at N → rsp_valid at N+5, rsp_id=1, rsp_flags=5'b00010. dp_* constant during N+1..N+4.
- Contention: req0 and req1 both continuously valid with integer ops, rsp_ready=1. Grants alternate 0,1,0,1; each accept is spaced 4 cycles apart (accept, EXEC, DONE, IDLE bubble).
- Backpressure: rsp_ready held 0 for 6 cycles in DONE. rsp_valid and rsp_result remain stable and req*_ready stays 0; completes on the first rsp_ready=1.
- Flush: flush asserted during the 2nd EXEC cycle of an FP op. Next cycle state IDLE, rsp_valid never rises, the following req0 op is accepted normally.
- Async reset: rst pulsed mid-cycle during DONE. All outputs go to 0 immediately without a clock edge; the rr pointer returns to 0.

Source files
------------

// File: rtl/ex_unit_sched.sv
// Purpose: round-robin scheduler sharing one RV32IF execute datapath (ALU + FPU) between two issue requesters.
// Latency: accept -> rsp_valid after 1 + INT_LATENCY / 1 + FP_LATENCY cycles; one op in flight, one idle bubble after each response.
// Backpressure: rsp_* held while rsp_valid & !rsp_ready; req*_ready only in IDLE, so new ops wait until the response is taken.
`timescale 1ns/1ps
module ex_unit_sched #(
   parameter int WIDTH       = 32,
   parameter int INT_LATENCY = 1,
   parameter int FP_LATENCY  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_opa,
   input  logic [WIDTH-1:0] req0_opb,
   input  logic [3:0]       req0_ctrl,
   input  logic [1:0]       req0_ext,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_opa,
   input  logic [WIDTH-1:0] req1_opb,
   input  logic [3:0]       req1_ctrl,
   input  logic [1:0]       req1_ext,
   output logic [WIDTH-1:0] dp_opa,
   output logic [WIDTH-1:0] dp_opb,
   output logic [3:0]       dp_ctrl,
   output logic [1:0]       dp_ext,
   input  logic [WIDTH-1:0] dp_result,
   input  logic             dp_zero,
   input  logic             dp_sign,
   input  logic             dp_exception,
   input  logic             dp_overflow,
   input  logic             dp_underflow,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic [4:0]       rsp_flags,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

   localparam int MAX_LAT = (FP_LATENCY > INT_LATENCY) ? FP_LATENCY : INT_LATENCY;
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
   localparam logic [CNT_W-1:0] INT_CNT = CNT_W'(INT_LATENCY - 1);
   localparam logic [CNT_W-1:0] FP_CNT  = CNT_W'(FP_LATENCY - 1);

   state_t             state_q, state_d;
   logic               rr_q, rr_d;          // requester that wins the next contention
   logic               bubble_q, bubble_d;  // first IDLE cycle after a response: no accept
   logic               id_q, id_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   dp_opa_q, dp_opa_d;
   logic [WIDTH-1:0]   dp_opb_q, dp_opb_d;
   logic [3:0]         dp_ctrl_q, dp_ctrl_d;
   logic [1:0]         dp_ext_q, dp_ext_d;
   logic               rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
   logic [4:0]         rsp_flags_q, rsp_flags_d;

   logic               gnt0, gnt1, accept;
   logic [WIDTH-1:0]   sel_opa, sel_opb;
   logic [3:0]         sel_ctrl;
   logic [1:0]         sel_ext;

   // Grant: only in a non-bubble IDLE cycle without flush; contention resolved by rr_q.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state_q == S_IDLE && !bubble_q && !flush) begin
         if (req0_valid && req1_valid) begin
            gnt0 = !rr_q;
            gnt1 = rr_q;
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
      end
   end

   assign accept   = gnt0 | gnt1;
   assign sel_opa  = gnt1 ? req1_opa  : req0_opa;
   assign sel_opb  = gnt1 ? req1_opb  : req0_opb;
   assign sel_ctrl = gnt1 ? req1_ctrl : req0_ctrl;
   assign sel_ext  = gnt1 ? req1_ext  : req0_ext;

   // Next state: issue on accept, count down the class latency, hold the response until taken.
   always_comb begin
      state_d      = state_q;
      rr_d         = rr_q;
      bubble_d     = 1'b0;
      id_d         = id_q;
      cnt_d        = cnt_q;
      dp_opa_d     = dp_opa_q;
      dp_opb_d     = dp_opb_q;
      dp_ctrl_d    = dp_ctrl_q;
      dp_ext_d     = dp_ext_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               dp_opa_d  = sel_opa;
               dp_opb_d  = sel_opb;
               dp_ctrl_d = sel_ctrl;
               dp_ext_d  = sel_ext;
               id_d      = gnt1;
               rr_d      = !gnt1;
               cnt_d     = (sel_ext == 2'b11) ? FP_CNT : INT_CNT;
               state_d   = S_EXEC;
            end
         end
         S_EXEC: begin
            if (cnt_q == '0) begin
               rsp_id_d     = id_q;
               rsp_result_d = dp_result;
               // Only the flags meaningful for the op class are reported.
               if (dp_ext_q == 2'b11)
                  rsp_flags_d = {2'b00, dp_exception, dp_overflow, dp_underflow};
               else
                  rsp_flags_d = {dp_zero, dp_sign, 3'b000};
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DONE: begin
            if (rsp_ready) begin
               state_d  = S_IDLE;
               bubble_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Flush drops the op and any pending response; rr pointer untouched.
      if (flush) begin
         state_d  = S_IDLE;
         bubble_d = 1'b0;
      end
   end

   // State and datapath/response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         rr_q         <= 1'b0;
         bubble_q     <= 1'b0;
         id_q         <= 1'b0;
         cnt_q        <= '0;
         dp_opa_q     <= '0;
         dp_opb_q     <= '0;
         dp_ctrl_q    <= '0;
         dp_ext_q     <= '0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
      end else begin
         state_q      <= state_d;
         rr_q         <= rr_d;
         bubble_q     <= bubble_d;
         id_q         <= id_d;
         cnt_q        <= cnt_d;
         dp_opa_q     <= dp_opa_d;
         dp_opb_q     <= dp_opb_d;
         dp_ctrl_q    <= dp_ctrl_d;
         dp_ext_q     <= dp_ext_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign dp_opa     = dp_opa_q;
   assign dp_opb     = dp_opb_q;
   assign dp_ctrl    = dp_ctrl_q;
   assign dp_ext     = dp_ext_q;
   assign rsp_valid  = (state_q == S_DONE);
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_flags  = rsp_flags_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ex_unit_sched.sv
// Purpose: directed bench for ex_unit_sched: int op, FP op, contention, backpressure, flush, async reset.
// Latency: expectations are hand-computed cycle by cycle; inputs driven and outputs sampled on the falling edge.
// Backpressure: rsp_ready held low for several DONE cycles; response must stay stable.
`timescale 1ns/1ps
module tb_ex_unit_sched;

   logic        clk = 1'b0;
   logic        rst, flush;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_opa, req0_opb, req1_opa, req1_opb;
   logic [3:0]  req0_ctrl, req1_ctrl;
   logic [1:0]  req0_ext, req1_ext;
   logic [31:0] dp_opa, dp_opb;
   logic [3:0]  dp_ctrl;
   logic [1:0]  dp_ext;
   logic [31:0] dp_result;
   logic        dp_zero, dp_sign, dp_exception, dp_overflow, dp_underflow;
   logic        rsp_valid, rsp_ready, rsp_id, busy;
   logic [31:0] rsp_result;
   logic [4:0]  rsp_flags;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ex_unit_sched dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_opa(req0_opa), .req0_opb(req0_opb), .req0_ctrl(req0_ctrl), .req0_ext(req0_ext),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_opa(req1_opa), .req1_opb(req1_opb), .req1_ctrl(req1_ctrl), .req1_ext(req1_ext),
      .dp_opa(dp_opa), .dp_opb(dp_opb), .dp_ctrl(dp_ctrl), .dp_ext(dp_ext),
      .dp_result(dp_result), .dp_zero(dp_zero), .dp_sign(dp_sign),
      .dp_exception(dp_exception), .dp_overflow(dp_overflow), .dp_underflow(dp_underflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; rsp_ready = 1'b0;
      req0_valid = 1'b0; req0_opa = '0; req0_opb = '0; req0_ctrl = '0; req0_ext = '0;
      req1_valid = 1'b0; req1_opa = '0; req1_opb = '0; req1_ctrl = '0; req1_ext = '0;
      dp_result = '0; dp_zero = 1'b0; dp_sign = 1'b0;
      dp_exception = 1'b0; dp_overflow = 1'b0; dp_underflow = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dp_opa", dp_opa, 0);
      chk("rst_rsp_flags", rsp_flags, 0);
      chk("rst_rdy0", req0_ready, 0);
      @(negedge clk); rst = 1'b0;

      // Integer SUB 5-5: zero=1; overflow input must be masked
      @(negedge clk);
      req0_valid = 1'b1; req0_opa = 32'd5; req0_opb = 32'd5; req0_ctrl = 4'h1; req0_ext = 2'b00;
      dp_result = 32'h0; dp_zero = 1'b1; dp_overflow = 1'b1;
      #1;
      chk("int_rdy0", req0_ready, 1);
      chk("int_rdy1", req1_ready, 0);
      @(negedge clk); req0_valid = 1'b0; #1;
      chk("int_exec_busy", busy, 1);
      chk("int_exec_rsp_valid", rsp_valid, 0);
      chk("int_dp_opa", dp_opa, 5);
      chk("int_dp_ctrl", dp_ctrl, 1);
      @(negedge clk); #1;
      chk("int_rsp_valid", rsp_valid, 1);
      chk("int_rsp_id", rsp_id, 0);
      chk("int_rsp_result", rsp_result, 0);
      chk("int_rsp_flags", rsp_flags, 5'b10000);
      rsp_ready = 1'b1;
      @(negedge clk); rsp_ready = 1'b0; #1;
      chk("int_after_rsp_valid", rsp_valid, 0);
      chk("int_after_busy", busy, 0);

      // FP op from req1: overflow flag, zero/sign masked
      @(negedge clk);
      req1_valid = 1'b1; req1_opa = 32'h4000_0000; req1_opb = 32'h3F80_0000; req1_ctrl = 4'h3; req1_ext = 2'b11;
      dp_result = 32'h7F80_0000; dp_zero = 1'b1; dp_sign = 1'b1; dp_overflow = 1'b1;
      #1;
      chk("fp_rdy1", req1_ready, 1);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (i == 1) begin req1_valid = 1'b0; req1_opa = 32'hDEAD_BEEF; req1_ext = 2'b00; end
         #1;
         chk("fp_dp_opa_hold", dp_opa, 32'h4000_0000);
         chk("fp_dp_ext_hold", dp_ext, 2'b11);
         chk("fp_exec_rsp_valid", rsp_valid, 0);
      end
      @(negedge clk); #1;
      chk("fp_rsp_valid", rsp_valid, 1);
      chk("fp_rsp_id", rsp_id, 1);
      chk("fp_rsp_result", rsp_result, 32'h7F80_0000);
      chk("fp_rsp_flags", rsp_flags, 5'b00010);

      // Backpressure: response held, no new grants
      req0_valid = 1'b1; req0_opa = 32'h77; req0_ext = 2'b00;
      dp_result = 32'h1111_1111;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_rsp_result", rsp_result, 32'h7F80_0000);
         chk("bp_rdy0", req0_ready, 0);
      end
      @(negedge clk); rsp_ready = 1'b1; #1;
      chk("bp_last_rsp_valid", rsp_valid, 1);
      @(negedge clk); rsp_ready = 1'b0; #1;
      chk("bp_done_rsp_valid", rsp_valid, 0);
      chk("bubble_rdy0", req0_ready, 0);
      req0_valid = 1'b0;

      // Contention: both valid int ops, grants 0,1,0,1 every 4 cycles
      req0_opa = 32'h11; req0_ext = 2'b00; req0_ctrl = 4'h0;
      req1_opa = 32'h22; req1_ext = 2'b00; req1_ctrl = 4'h0;
      dp_result = 32'hABCD; dp_zero = 1'b0; dp_sign = 1'b1; dp_overflow = 1'b0;
      rsp_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         int ph, eid;
         @(negedge clk);
         if (k == 0) begin req0_valid = 1'b1; req1_valid = 1'b1; end
         #1;
         ph  = k % 4;
         eid = (k / 4) % 2;
         chk("cont_rdy0", req0_ready, (ph == 0 && eid == 0) ? 1 : 0);
         chk("cont_rdy1", req1_ready, (ph == 0 && eid == 1) ? 1 : 0);
         if (ph == 1) chk("cont_dp_opa", dp_opa, (eid == 1) ? 32'h22 : 32'h11);
         if (ph == 2) begin
            chk("cont_rsp_valid", rsp_valid, 1);
            chk("cont_rsp_id", rsp_id, eid);
            chk("cont_rsp_flags", rsp_flags, 5'b01000);
         end
      end
      @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;

      // Flush during 2nd EXEC cycle of an FP op
      @(negedge clk);
      req1_valid = 1'b1; req1_opa = 32'h3F00_0000; req1_ext = 2'b11; #1;
      chk("fl_rdy1", req1_ready, 1);
      @(negedge clk); req1_valid = 1'b0;
      @(negedge clk); flush = 1'b1;
      @(negedge clk); flush = 1'b0; #1;
      chk("fl_busy", busy, 0);
      chk("fl_rsp_valid", rsp_valid, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         chk("fl_no_rsp", rsp_valid, 0);
      end
      // Flush in IDLE suppresses ready only
      @(negedge clk);
      flush = 1'b1; req0_valid = 1'b1; req0_opa = 32'h9; req0_ext = 2'b00; #1;
      chk("fl_idle_rdy0", req0_ready, 0);
      @(negedge clk); flush = 1'b0; #1;
      chk("post_fl_rdy0", req0_ready, 1);
      dp_result = 32'h1234; dp_zero = 1'b0; dp_sign = 1'b0;
      @(negedge clk); req0_valid = 1'b0; #1;
      chk("post_fl_dp_opa", dp_opa, 32'h9);
      chk("post_fl_busy", busy, 1);
      @(negedge clk); #1;
      chk("post_fl_rsp_valid", rsp_valid, 1);
      chk("post_fl_rsp_result", rsp_result, 32'h1234);
      chk("post_fl_rsp_id", rsp_id, 0);

      // Async reset mid-DONE, between clock edges
      #2 rst = 1'b1;
      #1;
      chk("arst_rsp_valid", rsp_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_dp_opa", dp_opa, 0);
      chk("arst_rsp_result", rsp_result, 0);
      chk("arst_dp_ext", dp_ext, 0);
      @(negedge clk);
      rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; #1;
      chk("arst_rr_rdy0", req0_ready, 1);
      chk("arst_rr_rdy1", req1_ready, 0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
